// File: rtl/id_stage_pipe.sv
// ============================================================================
// id_stage_pipe : decode stage with register file and stallable ID/EX register
// Optional macro ID_BYPASS_EN : write-first register file reads
// Revision 1.0
// ============================================================================
`default_nettype none

module ControlUnit (
  input  logic [1:0] i_mode,
  input  logic [3:0] i_opcode,
  input  logic       i_s,
  output logic [3:0] o_exe_cmd,
  output logic       o_wb_en,
  output logic       o_mem_r_en,
  output logic       o_mem_w_en,
  output logic       o_b,
  output logic       o_s
);
  always_comb begin
    o_exe_cmd  = 4'b0000;
    o_wb_en    = 1'b0;
    o_mem_r_en = 1'b0;
    o_mem_w_en = 1'b0;
    o_b        = 1'b0;
    o_s        = 1'b0;
    case (i_mode)
      2'b00: begin
        o_s = i_s;
        case (i_opcode)
          4'b1101: begin o_exe_cmd = 4'b0001; o_wb_en = 1'b1; end // MOV
          4'b1111: begin o_exe_cmd = 4'b1001; o_wb_en = 1'b1; end // MVN
          4'b0100: begin o_exe_cmd = 4'b0010; o_wb_en = 1'b1; end // ADD
          4'b0101: begin o_exe_cmd = 4'b0011; o_wb_en = 1'b1; end // ADC
          4'b0010: begin o_exe_cmd = 4'b0100; o_wb_en = 1'b1; end // SUB
          4'b0110: begin o_exe_cmd = 4'b0101; o_wb_en = 1'b1; end // SBC
          4'b0000: begin o_exe_cmd = 4'b0110; o_wb_en = 1'b1; end // AND
          4'b1100: begin o_exe_cmd = 4'b0111; o_wb_en = 1'b1; end // ORR
          4'b0001: begin o_exe_cmd = 4'b1000; o_wb_en = 1'b1; end // EOR
          4'b1010: o_exe_cmd = 4'b0100;                          // CMP
          4'b1000: o_exe_cmd = 4'b0110;                          // TST
          default: ;
        endcase
      end
      2'b01: begin
        o_exe_cmd = 4'b0010;
        if (i_s) begin
          o_mem_r_en = 1'b1;
          o_wb_en    = 1'b1;
        end else begin
          o_mem_w_en = 1'b1;
        end
      end
      2'b10: o_b = 1'b1;
      default: ;
    endcase
  end
endmodule

module ConditionCheck (
  input  logic [3:0] i_cond,
  input  logic [3:0] i_status,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_status;

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      4'h0: o_pass = w_z;
      4'h1: o_pass = ~w_z;
      4'h2: o_pass = w_c;
      4'h3: o_pass = ~w_c;
      4'h4: o_pass = w_n;
      4'h5: o_pass = ~w_n;
      4'h6: o_pass = w_v;
      4'h7: o_pass = ~w_v;
      4'h8: o_pass = w_c & ~w_z;
      4'h9: o_pass = ~w_c | w_z;
      4'hA: o_pass = (w_n == w_v);
      4'hB: o_pass = (w_n != w_v);
      4'hC: o_pass = ~w_z & (w_n == w_v);
      4'hD: o_pass = w_z | (w_n != w_v);
      4'hE: o_pass = 1'b1;
      default: o_pass = 1'b0; // 1111 never executes
    endcase
  end
endmodule

module id_stage_pipe #(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 16,
  parameter  int PC_W    = 32,
  localparam int REG_AW  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              hazard,
  input  logic [3:0]        status_reg,
  input  logic              wb_wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [31:0]       instruction,
  output logic [3:0]        id_src1,
  output logic [3:0]        id_src2,
  output logic              id_two_src,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic [3:0]        ex_exe_cmd,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic              ex_imm
);

  logic [3:0] w_cond, w_opcode, w_rn, w_rd, w_rm;
  logic [1:0] w_mode;
  logic       w_imm, w_s_bit;

  assign w_cond   = instruction[31:28];
  assign w_mode   = instruction[27:26];
  assign w_imm    = instruction[25];
  assign w_opcode = instruction[24:21];
  assign w_s_bit  = instruction[20];
  assign w_rn     = instruction[19:16];
  assign w_rd     = instruction[15:12];
  assign w_rm     = instruction[3:0];

  logic [3:0] w_cu_cmd;
  logic       w_cu_wb, w_cu_mr, w_cu_mw, w_cu_b, w_cu_s;
  logic       w_cond_pass, w_bubble_n;

  ControlUnit u_cu (
    .i_mode     (w_mode),
    .i_opcode   (w_opcode),
    .i_s        (w_s_bit),
    .o_exe_cmd  (w_cu_cmd),
    .o_wb_en    (w_cu_wb),
    .o_mem_r_en (w_cu_mr),
    .o_mem_w_en (w_cu_mw),
    .o_b        (w_cu_b),
    .o_s        (w_cu_s)
  );

  ConditionCheck u_cc (
    .i_cond   (w_cond),
    .i_status (status_reg),
    .o_pass   (w_cond_pass)
  );

  assign w_bubble_n = w_cond_pass & ~hazard;

  // Raw store decode keeps the source select independent of the hazard input.
  assign id_src1    = w_rn;
  assign id_src2    = w_cu_mw ? w_rd : w_rm;
  assign id_two_src = ~w_imm | w_cu_mw;

  logic [DATA_W-1:0] r_regs [REG_CNT];
  logic [REG_AW-1:0] w_rd1_idx, w_rd2_idx;
  logic [DATA_W-1:0] w_val_rn, w_val_rm;

  assign w_rd1_idx = REG_AW'(id_src1);
  assign w_rd2_idx = REG_AW'(id_src2);

`ifdef ID_BYPASS_EN
  assign w_val_rn = (wb_wb_en && (wb_dest == w_rd1_idx)) ? wb_value : r_regs[w_rd1_idx];
  assign w_val_rm = (wb_wb_en && (wb_dest == w_rd2_idx)) ? wb_value : r_regs[w_rd2_idx];
`else
  assign w_val_rn = r_regs[w_rd1_idx];
  assign w_val_rm = r_regs[w_rd2_idx];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else if (wb_wb_en) begin
      r_regs[wb_dest] <= wb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid         <= 1'b0;
      ex_wb_en         <= 1'b0;
      ex_mem_r_en      <= 1'b0;
      ex_mem_w_en      <= 1'b0;
      ex_b             <= 1'b0;
      ex_s             <= 1'b0;
      ex_exe_cmd       <= 4'b0000;
      ex_pc            <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_dest          <= 4'h0;
      ex_src1          <= 4'h0;
      ex_src2          <= 4'h0;
      ex_shift_operand <= 12'h000;
      ex_signed_imm_24 <= 24'h000000;
      ex_imm           <= 1'b0;
    end else begin
      // Data fields follow the control path on flush; they are unused then.
      if (flush || !stall) begin
        ex_pc            <= pc_in;
        ex_val_rn        <= w_val_rn;
        ex_val_rm        <= w_val_rm;
        ex_dest          <= w_rd;
        ex_src1          <= id_src1;
        ex_src2          <= id_src2;
        ex_shift_operand <= instruction[11:0];
        ex_signed_imm_24 <= instruction[23:0];
        ex_imm           <= w_imm;
      end
      if (flush) begin
        ex_valid    <= 1'b0;
        ex_wb_en    <= 1'b0;
        ex_mem_r_en <= 1'b0;
        ex_mem_w_en <= 1'b0;
        ex_b        <= 1'b0;
        ex_s        <= 1'b0;
        ex_exe_cmd  <= 4'b0000;
      end else if (!stall) begin
        ex_valid    <= w_bubble_n;
        ex_wb_en    <= w_cu_wb & w_bubble_n;
        ex_mem_r_en <= w_cu_mr & w_bubble_n;
        ex_mem_w_en <= w_cu_mw & w_bubble_n;
        ex_b        <= w_cu_b & w_bubble_n;
        ex_s        <= w_cu_s & w_bubble_n;
        ex_exe_cmd  <= w_bubble_n ? w_cu_cmd : 4'b0000;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// tb_id_stage_pipe : directed + randomized checks of id_stage_pipe against a
// behavioural model. Honours ID_BYPASS_EN. Revision 1.0
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, hazard, wb_wb_en;
  logic [3:0]  status_reg, wb_dest;
  logic [31:0] wb_value, pc_in, instruction;
  logic [3:0]  id_src1, id_src2;
  logic        id_two_src, ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
  logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_signed_imm_24;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .hazard(hazard),
    .status_reg(status_reg), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .pc_in(pc_in), .instruction(instruction),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_shift_operand(ex_shift_operand),
    .ex_signed_imm_24(ex_signed_imm_24), .ex_imm(ex_imm)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [16];
  logic        e_valid, e_wb, e_mr, e_mw, e_b, e_s, e_imm, e_known;
  logic [3:0]  e_cmd, e_dest, e_src1, e_src2;
  logic [31:0] e_pc, e_rn, e_rm;
  logic [11:0] e_shift;
  logic [23:0] e_imm24;

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // returns {cmd[3:0], wb, mem_r, mem_w, b, s} before condition gating
  function automatic logic [8:0] decode(input logic [31:0] ins);
    logic [3:0] op;
    op = ins[24:21];
    if (ins[27:26] == 2'b00) begin
      case (op)
        4'b1101: return {4'd1, 1'b1, 3'b000, ins[20]};
        4'b1111: return {4'd9, 1'b1, 3'b000, ins[20]};
        4'b0100: return {4'd2, 1'b1, 3'b000, ins[20]};
        4'b0101: return {4'd3, 1'b1, 3'b000, ins[20]};
        4'b0010: return {4'd4, 1'b1, 3'b000, ins[20]};
        4'b0110: return {4'd5, 1'b1, 3'b000, ins[20]};
        4'b0000: return {4'd6, 1'b1, 3'b000, ins[20]};
        4'b1100: return {4'd7, 1'b1, 3'b000, ins[20]};
        4'b0001: return {4'd8, 1'b1, 3'b000, ins[20]};
        4'b1010: return {4'd4, 1'b0, 3'b000, ins[20]};
        4'b1000: return {4'd6, 1'b0, 3'b000, ins[20]};
        default: return {4'd0, 1'b0, 3'b000, ins[20]};
      endcase
    end else if (ins[27:26] == 2'b01) begin
      return ins[20] ? 9'b0010_11000 : 9'b0010_00100;
    end else if (ins[27:26] == 2'b10) begin
      return 9'b0000_00010;
    end
    return 9'd0;
  endfunction

  // One clock: check combinational outputs, advance model, compare registered outputs.
  task automatic step();
    logic [8:0]  d;
    logic [3:0]  s1, s2;
    logic [31:0] rn, rm;
    bit          store, live;
    #1;
    d     = decode(instruction);
    store = (instruction[27:26] == 2'b01) && !instruction[20];
    s1    = instruction[19:16];
    s2    = store ? instruction[15:12] : instruction[3:0];
    chk("id_src1", id_src1, s1);
    chk("id_src2", id_src2, s2);
    chk("id_two_src", id_two_src, !instruction[25] || store);
    rn = (BYP && wb_wb_en && wb_dest == s1) ? wb_value : m_rf[s1];
    rm = (BYP && wb_wb_en && wb_dest == s2) ? wb_value : m_rf[s2];
    live = cond_holds(instruction[31:28], status_reg) && !hazard;
    if (!rst) begin
      {e_valid, e_wb, e_mr, e_mw, e_b, e_s, e_imm} = '0;
      {e_cmd, e_dest, e_src1, e_src2, e_pc, e_rn, e_rm, e_shift, e_imm24} = '0;
      e_known = 1;
    end else if (flush || !stall) begin
      e_pc = pc_in; e_rn = rn; e_rm = rm; e_dest = instruction[15:12];
      e_src1 = s1; e_src2 = s2; e_shift = instruction[11:0];
      e_imm24 = instruction[23:0]; e_imm = instruction[25];
      e_known = !flush;
      if (flush) begin
        {e_valid, e_wb, e_mr, e_mw, e_b, e_s} = '0;
        e_cmd = 0;
      end else begin
        e_valid = live;
        {e_cmd, e_wb, e_mr, e_mw, e_b, e_s} = live ? d : 9'd0;
      end
    end
    @(posedge clk);
    if (!rst) for (int i = 0; i < 16; i++) m_rf[i] = 0;
    else if (wb_wb_en) m_rf[wb_dest] = wb_value;
    #1;
    chk("ex_valid", ex_valid, e_valid);
    chk("ex_ctrl", {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s}, {e_wb, e_mr, e_mw, e_b, e_s});
    chk("ex_exe_cmd", ex_exe_cmd, e_cmd);
    if (e_known) begin
      chk("ex_pc", ex_pc, e_pc);
      chk("ex_val_rn", ex_val_rn, e_rn);
      chk("ex_val_rm", ex_val_rm, e_rm);
      chk("ex_idx", {ex_dest, ex_src1, ex_src2}, {e_dest, e_src1, e_src2});
      chk("ex_imm_fields", {ex_shift_operand, ex_signed_imm_24, ex_imm}, {e_shift, e_imm24, e_imm});
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; hazard = 0; wb_wb_en = 0; wb_dest = 0; wb_value = 0;
    status_reg = 4'b0000; instruction = 32'h0000_0000; rst = 1;
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
    idle_inputs();
    wb_wb_en = 1; wb_dest = idx; wb_value = val;
    step();
  endtask

  initial begin
    idle_inputs();
    pc_in = 32'h100;
    rst = 0;
    step();
    chk("reset_valid", ex_valid, 1'b0);

    // Preload, then reset must clear both the ID/EX register and the file.
    for (int i = 0; i < 16; i++) write_reg(i[3:0], 32'h1000 + i);
    idle_inputs(); rst = 0; stall = 1; instruction = 32'hE0821003;
    step();
    chk("rst_ex_wb", ex_wb_en, 1'b0);
    chk("rst_ex_rn", ex_val_rn, 32'h0);
    chk("rst_ex_valid", ex_valid, 1'b0);
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      instruction = 32'hE0800000 | (32'(i) << 16) | 32'(i);
      step();
      chk("rst_read_clear", ex_val_rn, 32'h0);
    end

    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd7);
    write_reg(4'd4, 32'hAB);

    // ADD R1,R2,R3
    idle_inputs(); instruction = 32'hE0821003; pc_in = 32'h200;
    step();
    chk("add_cmd", ex_exe_cmd, 4'b0010);
    chk("add_wb", ex_wb_en, 1'b1);
    chk("add_rn", ex_val_rn, 32'd5);
    chk("add_rm", ex_val_rm, 32'd7);
    chk("add_dest", ex_dest, 4'd1);
    chk("add_valid", ex_valid, 1'b1);

    // STR R4,[R2]
    idle_inputs(); instruction = 32'hE5824000;
    #1;
    chk("str_src2", id_src2, 4'd4);
    chk("str_two_src", id_two_src, 1'b1);
    step();
    chk("str_rm", ex_val_rm, 32'hAB);
    chk("str_mem_w", ex_mem_w_en, 1'b1);

    // EQ with Z clear, then AL with hazard: both bubbles
    idle_inputs(); instruction = 32'h00821003; status_reg = 4'b0000;
    step();
    chk("eq_fail_valid", ex_valid, 1'b0);
    chk("eq_fail_ctrl", {ex_wb_en, ex_exe_cmd}, 5'b0);
    idle_inputs(); instruction = 32'hE0821003; hazard = 1;
    step();
    chk("hazard_valid", ex_valid, 1'b0);
    chk("hazard_ctrl", {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd}, 9'b0);

    // Stall holds ADD for three cycles, then flush beats stall
    idle_inputs(); instruction = 32'hE0821003;
    step();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); stall = 1; instruction = (k == 1) ? 32'hE5824000 : 32'hEA000010;
      step();
      chk("stall_hold_rn", ex_val_rn, 32'd5);
      chk("stall_hold_cmd", {ex_valid, ex_exe_cmd}, 5'b1_0010);
    end
    idle_inputs(); stall = 1; flush = 1; instruction = 32'hE0821003;
    step();
    chk("flush_stall", {ex_valid, ex_wb_en, ex_exe_cmd}, 6'b0);

    // Same-cycle write to R2 while decoding ADD reading R2
    idle_inputs(); instruction = 32'hE0821003; wb_wb_en = 1; wb_dest = 2; wb_value = 99;
    step();
    chk("bypass_rn", ex_val_rn, BYP ? 32'd99 : 32'd5);
    idle_inputs(); instruction = 32'hE0821003;
    step();
    chk("after_write_rn", ex_val_rn, 32'd99);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(63) != 0);
      stall    = ($urandom_range(5) == 0);
      flush    = ($urandom_range(9) == 0);
      hazard   = ($urandom_range(7) == 0);
      wb_wb_en = $urandom_range(1);
      wb_dest  = 4'($urandom_range(15));
      wb_value = $urandom;
      status_reg = 4'($urandom_range(15));
      pc_in    = $urandom;
      instruction = $urandom;
      if ($urandom_range(1) == 1) instruction[31:28] = 4'hE;
      if ($urandom_range(2) == 0) instruction[27:26] = 2'b01;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage with its own ID/EX pipeline register.
- Decodes a 32-bit instruction, reads a parametrised register file and applies the condition/hazard bubble.
- Latches all execute-side fields into a stallable, flushable register, so the stage drives the EX stage directly.
- Sits between the IF/ID register and the EX stage.
- Exports source indices for the hazard and forwarding units.

Parameters:
- DATA_W, 32, register file and operand width
- REG_CNT, 16, register file depth; power of two, 16..64; instruction fields address entries 0-15 only
- PC_W, 32, program counter width
- REG_AW, $clog2(REG_CNT), register index width; derived, not overridden

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hold ID/EX register contents
- flush  in  1  load a bubble into ID/EX (branch taken)
- hazard  in  1  data hazard from hazard unit; current instruction becomes a bubble
- status_reg  in  4  NZCV flags for condition check
- wb_wb_en  in  1  register file write enable
- wb_dest  in  REG_AW  write index
- wb_value  in  DATA_W  write data
- pc_in  in  PC_W  PC of instruction in ID
- instruction  in  32  instruction word
- id_src1, id_src2  out  4  combinational source indices (Rn; Rd if store else Rm)
- id_two_src  out  1  combinational: ~instruction[25] or decoded store
- ex_valid  out  1  ID/EX holds a real (non-bubble) instruction
- ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s  out  1 each  registered control
- ex_exe_cmd  out  4  registered ALU command
- ex_pc  out  PC_W  registered PC
- ex_val_rn, ex_val_rm  out  DATA_W  registered operands
- ex_dest  out  4  registered Rd
- ex_src1, ex_src2  out  4  registered source indices for forwarding
- ex_shift_operand  out  12  registered instruction[11:0]
- ex_signed_imm_24  out  24  registered instruction[23:0]
- ex_imm  out  1  registered instruction[25]

Behaviour:
- Field extraction: cond = [31:28], mode = [27:26], imm = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12], Rm = [3:0].
- Control and condition logic instantiate existing ControlUnit and ConditionCheck unchanged.
- bubble_n = condition_pass & ~hazard.
- When bubble_n = 0: wb_en, mem_r_en, mem_w_en, b, s = 0 and exe_cmd = 0000. Data fields are still computed.
- Store detection for src2 uses the raw ControlUnit mem_w_en, not the gated one. This avoids a combinational loop.
- Register file:
  - REG_CNT x DATA_W, written at rising clk when wb_wb_en = 1.
  - Read is asynchronous; 4-bit indices zero-extended to REG_AW.
- ID/EX update priority, evaluated at rising clk:
  - rst = 0: all ex_* outputs and all register file entries = 0; ex_valid = 0.
  - else flush = 1: all control outputs = 0, ex_valid = 0. Data fields load normally; they are don't-care.
  - else stall = 1: every ex_* output holds its value.
  - else: load decoded values; ex_valid = bubble_n.
- flush and stall in the same cycle: flush wins.
- hazard with stall = 0: a bubble is loaded (ex_valid = 0). The upstream IF/ID hold is the hazard unit's responsibility.
- Latency: ID to ex_* outputs is one cycle.
- Register file writes are not blocked by stall or flush.
- Reset mid-stall: reset wins, and the register file is cleared.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined: if wb_wb_en = 1 and wb_dest equals a read index in the same cycle, that read returns wb_value (write-first). The registered operand captures the new value.
- Undefined: the read returns the pre-write register contents. The hazard unit must cover the WB distance.
- Applies to both read ports independently.

Test Plan:
- Reset: hold rst = 0 one cycle with register file preloaded -> all ex_* = 0, ex_valid = 0; later reads of R0-R15 return 0.
- ADD R1,R2,R3 (0xE0821003), R2 = 5, R3 = 7 -> next cycle ex_exe_cmd = 0010, ex_wb_en = 1, ex_val_rn = 5, ex_val_rm = 7, ex_dest = 1, ex_valid = 1.
- STR R4,[R2] with R4 = 0xAB -> id_src2 = 4, id_two_src = 1, ex_val_rm = 0xAB, ex_mem_w_en = 1.
- EQ-conditioned instruction with Z = 0, or hazard = 1 -> all registered control = 0, exe_cmd = 0000, ex_valid = 0.
- Load ADD, then stall = 1 for 3 cycles with new instructions presented -> ex_* unchanged. Assert flush and stall together -> control zero, ex_valid = 0.
- wb_wb_en = 1, wb_dest = 2, wb_value = 99 while decoding ADD reading R2 -> ex_val_rn = 99 with ID_BYPASS_EN defined, old R2 value without it.
